// File: rtl/lb_master_bridge_pkg.sv
// Shared local-bus definitions: bridge FSM encoding, default widths and error data,
// also used by the CSR responders.
package lb_master_bridge_pkg;

  localparam int          LB_ADDR_W    = 32;
  localparam int          LB_DATA_W    = 32;
  localparam int          LB_STRB_W    = LB_DATA_W / 8;
  localparam int          LB_TIMEOUT   = 16;
  localparam logic [31:0] LB_BASE_ADDR = 32'h0300_0000;
  localparam logic [31:0] LB_ERR_DATA  = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } lb_state_e;

endpackage

// File: rtl/lb_master_bridge.sv
// Initiator end of the local CSR bus: turns one PicoRV32 native memory request into a
// single local-bus write or read, with a timeout that completes hung accesses.
module lb_master_bridge
  import lb_master_bridge_pkg::*;
#(
  parameter int                  ADDR_W    = LB_ADDR_W,
  parameter int                  DATA_W    = LB_DATA_W,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = LB_BASE_ADDR,
  parameter int                  TIMEOUT   = LB_TIMEOUT,
  parameter logic [DATA_W-1:0]   ERR_DATA  = LB_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic [ADDR_W-1:0]     waddr,
  output logic [DATA_W-1:0]     wdata,
  output logic                  wen,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wready,
  output logic [ADDR_W-1:0]     raddr,
  output logic                  ren,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rvalid,
  output logic                  bus_err,
  input  logic                  bus_err_clr
);

  localparam int              CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  lb_state_e                 r_state;
  lb_state_e                 w_next;
  logic                      w_hs;
  logic                      w_tmo;
  logic [CNT_W-1:0]          r_cnt;
  logic [ADDR_W-1:0]         r_addr;
  logic [DATA_W-1:0]         r_wdata;
  logic [DATA_W/8-1:0]       r_wstrb;
  logic [DATA_W-1:0]         r_rdata;
  logic                      r_wen;
  logic                      r_ren;
  logic                      r_ready;
  logic                      r_err;

  // A handshake in the limit cycle takes priority over the timeout.
  always_comb begin
    w_next = r_state;
    w_hs   = 1'b0;
    w_tmo  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          w_next = (|mem_wstrb) ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        w_hs = wready;
        if (wready) begin
          w_next = ST_RESP;
        end else if (r_cnt == CNT_LIMIT) begin
          w_next = ST_RESP;
          w_tmo  = 1'b1;
        end
      end
      ST_RD: begin
        w_hs = rvalid;
        if (rvalid) begin
          w_next = ST_RESP;
        end else if (r_cnt == CNT_LIMIT) begin
          w_next = ST_RESP;
          w_tmo  = 1'b1;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Bus strobes are registered from the next state so they rise and fall on FSM edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_wen   <= 1'b0;
      r_ren   <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wen   <= (w_next == ST_WR);
      r_ren   <= (w_next == ST_RD);
      r_ready <= (w_next == ST_RESP);

      if (r_state == ST_IDLE && mem_valid) begin
        r_addr  <= mem_addr - BASE_ADDR;
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
      end

      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else if ((r_state == ST_WR || r_state == ST_RD) && !w_hs && !w_tmo) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state == ST_RD && rvalid) begin
        r_rdata <= rdata;
      end else if (r_state == ST_RD && w_tmo) begin
        r_rdata <= ERR_DATA;
      end else if (r_state == ST_WR && (wready || w_tmo)) begin
        r_rdata <= '0;
      end

      if (w_tmo) begin
        r_err <= 1'b1;
      end else if (bus_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign waddr     = r_addr;
  assign raddr     = r_addr;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign wen       = r_wen;
  assign ren       = r_ren;
  assign bus_err   = r_err;

endmodule
